// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: connection between the arbiter and the shared sequential multiplier.
//
// Signals:
//   m_opstart       one-cycle start pulse to the multiplier
//   m_opclear       one-cycle clear pulse to the multiplier
//   m_multiplicand  operand A (WIDTH bits)
//   m_multiplier    operand B (WIDTH bits)
//   m_opdone        multiplier finished; level, held until m_opclear
//   m_result        product (2*WIDTH bits), valid while m_opdone=1
//
// Modports:
//   master  arbiter side (drives start/clear/operands)
//   slave   multiplier side (drives done/result)
interface mul_arbiter_if #(
   parameter int unsigned WIDTH = 64
);
   logic               m_opstart;
   logic               m_opclear;
   logic [WIDTH-1:0]   m_multiplicand;
   logic [WIDTH-1:0]   m_multiplier;
   logic               m_opdone;
   logic [2*WIDTH-1:0] m_result;

   modport master (
      output m_opstart, m_opclear, m_multiplicand, m_multiplier,
      input  m_opdone, m_result
   );

   modport slave (
      input  m_opstart, m_opclear, m_multiplicand, m_multiplier,
      output m_opdone, m_result
   );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential WIDTHxWIDTH multiplier between two requesters.
// Requests are granted round-robin; the multiplier is sequenced through
// start / wait-for-done / clear and the 2*WIDTH product is returned to the
// granted requester with a one-cycle done pulse.
//
// Optional feature: define MUL_ARB_TIMEOUT_EN to abort a multiplication that has
// not finished after TIMEOUT cycles in WAIT (done + error pulse, result forced to 0).
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous reset, active-high
//   req[1:0]       level request per requester, held until its done
//   multiplicand0/multiplier0, multiplicand1/multiplier1   requester operands
//   grant[1:0]     one-hot, requester currently being served
//   done[1:0]      one-cycle pulse to the served requester when result is valid
//   result         product, held until the next done
//   error          one-cycle pulse on timeout abort (0 without MUL_ARB_TIMEOUT_EN)
//   mbus           multiplier connection (mul_arbiter_if.master)
module mul_arbiter #(
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req,
   input  logic [WIDTH-1:0]   multiplicand0,
   input  logic [WIDTH-1:0]   multiplier0,
   input  logic [WIDTH-1:0]   multiplicand1,
   input  logic [WIDTH-1:0]   multiplier1,
   output logic [1:0]         grant,
   output logic [1:0]         done,
   output logic [2*WIDTH-1:0] result,
   output logic               error,
   mul_arbiter_if.master      mbus
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StWait,
      StDone,
      StClear
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               last_q, last_d;    // index of the requester served last
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tout_q, tout_d;     // current DONE is a timeout abort
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      result_d = result_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`ifdef MUL_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      tout_d   = tout_q;
`endif
      case (state_q)
         StIdle: begin
            if (req != 2'b00) begin
               state_d = StLoad;
               // On contention, favour the requester not served last.
               if (req == 2'b11) grant_d = last_q ? 2'b01 : 2'b10;
               else              grant_d = req;
            end
         end
         StLoad: begin
            mcand_d  = grant_q[1] ? multiplicand1 : multiplicand0;
            mplier_d = grant_q[1] ? multiplier1   : multiplier0;
            state_d  = StStart;
         end
         StStart: begin
            // m_opdone is deliberately not looked at here: it may be stale.
            state_d = StWait;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt_d   = '0;
            tout_d  = 1'b0;
`endif
         end
         StWait: begin
            if (mbus.m_opdone) begin
               result_d = mbus.m_result;
               state_d  = StDone;
            end
`ifdef MUL_ARB_TIMEOUT_EN
            else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               result_d = '0;
               tout_d   = 1'b1;
               state_d  = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         StDone: begin
            last_d  = grant_q[1];
            state_d = StClear;
         end
         StClear: begin
            grant_d = 2'b00;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         grant_q  <= 2'b00;
         last_q   <= 1'b1;
         result_q <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         tout_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         result_q <= result_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q    <= cnt_d;
         tout_q   <= tout_d;
`endif
      end
   end

   assign grant               = grant_q;
   assign done                = (state_q == StDone) ? grant_q : 2'b00;
   assign result              = result_q;
   assign mbus.m_opstart      = (state_q == StStart);
   assign mbus.m_opclear      = (state_q == StClear);
   assign mbus.m_multiplicand = mcand_q;
   assign mbus.m_multiplier   = mplier_q;

`ifdef MUL_ARB_TIMEOUT_EN
   assign error = (state_q == StDone) && tout_q;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed self-checking bench for mul_arbiter with a behavioural
// sequential multiplier model and a scoreboard of expected products.
module tb_mul_arbiter;

   localparam int unsigned WIDTH = 64;
   localparam int unsigned TOUT  = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         req;
   logic [WIDTH-1:0]   multiplicand0, multiplier0, multiplicand1, multiplier1;
   logic [1:0]         grant, done;
   logic [2*WIDTH-1:0] result;
   logic               error;

   mul_arbiter_if #(.WIDTH(WIDTH)) mbus ();

   mul_arbiter #(
      .WIDTH   (WIDTH),
      .TIMEOUT (TOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .multiplicand0 (multiplicand0),
      .multiplier0   (multiplier0),
      .multiplicand1 (multiplicand1),
      .multiplier1   (multiplier1),
      .grant         (grant),
      .done          (done),
      .result        (result),
      .error         (error),
      .mbus          (mbus)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: product ready 'lat' cycles after start, held until clear.
   int   lat  = 3;
   bit   hang = 1'b0;
   int   mdl_cnt;
   logic mdl_busy;

   always @(posedge clk) begin
      if (reset) begin
         mdl_busy      <= 1'b0;
         mdl_cnt       <= 0;
         mbus.m_opdone <= 1'b0;
         mbus.m_result <= '0;
      end else if (mbus.m_opclear) begin
         mdl_busy      <= 1'b0;
         mbus.m_opdone <= 1'b0;
      end else if (mbus.m_opstart) begin
         mdl_busy      <= 1'b1;
         mdl_cnt       <= lat;
         mbus.m_result <= {{WIDTH{1'b0}}, mbus.m_multiplicand}
                          * {{WIDTH{1'b0}}, mbus.m_multiplier};
      end else if (mdl_busy && !mbus.m_opdone && !hang) begin
         if (mdl_cnt <= 1) mbus.m_opdone <= 1'b1;
         else              mdl_cnt <= mdl_cnt - 1;
      end
   end

   // Pulse counters, sampled on the active edge (pre-update values).
   int start_cnt = 0, clear_cnt = 0, done_cnt = 0, err_cnt = 0;
   bit bad_grant = 1'b0;

   always @(posedge clk) begin
      if (!reset) begin
         if (mbus.m_opstart) start_cnt <= start_cnt + 1;
         if (mbus.m_opclear) clear_cnt <= clear_cnt + 1;
         if (done != 2'b00)  done_cnt  <= done_cnt + 1;
         if (error)          err_cnt   <= err_cnt + 1;
         if (grant == 2'b11) bad_grant <= 1'b1;
      end
   end

   typedef struct {
      logic [1:0]   gnt;
      logic [127:0] prod;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   pend_base = 0;   // starts belonging to aborted operations
   int   exp_ops  = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [1:0] gnt, input logic [127:0] prod, input logic err);
      exp_t e;
      e.gnt  = gnt;
      e.prod = prod;
      e.err  = err;
      sb.push_back(e);
      exp_ops++;
   endtask

   task automatic wait_start(input int budget);
      int n;
      n = 0;
      while (mbus.m_opstart !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", {127'b0, mbus.m_opstart}, 128'd1);
   endtask

   // Wait for a done pulse, compare against the scoreboard head, then check the
   // clear pulse and grant release that follow it.
   task automatic wait_done(input int budget, input logic [1:0] drop, output int cyc);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (done == 2'b00 && n < budget) begin
         @(negedge clk);
         n++;
      end
      cyc = n;
      check("done_seen", {127'b0, done != 2'b00}, 128'd1);
      if (done == 2'b00) return;
      check("sb_nonempty", {127'b0, sb.size() != 0}, 128'd1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      check("done_onehot", done, e.gnt);
      check("grant_at_done", grant, e.gnt);
      check("result", result, e.prod);
      check("error", error, e.err);
      check("start_pulses", start_cnt - clear_cnt - pend_base, 1);
      req = req & ~drop;
      @(negedge clk);
      check("done_width", done, 2'b00);
      check("opclear", mbus.m_opclear, 1'b1);
      @(negedge clk);
      check("grant_released", grant, 2'b00);
      check("result_held", result, e.prod);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int d0, c0;
      reset = 1'b1;
      req   = 2'b00;
      multiplicand0 = '0;
      multiplier0   = '0;
      multiplicand1 = '0;
      multiplier1   = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_grant", grant, 2'b00);
      check("rst_done", done, 2'b00);
      check("rst_result", result, '0);
      check("rst_error", error, 1'b0);
      check("rst_opstart", mbus.m_opstart, 1'b0);
      check("rst_opclear", mbus.m_opclear, 1'b0);
      check("rst_mcand", mbus.m_multiplicand, '0);
      reset = 1'b0;
      @(negedge clk);

      // Simultaneous requests: requester 0 wins first after reset
      multiplicand0 = 64'd12; multiplier0 = 64'd12;
      multiplicand1 = 64'd3;  multiplier1 = 64'd5;
      push(2'b01, 128'd144, 1'b0);
      push(2'b10, 128'd15, 1'b0);
      req = 2'b11;
      wait_done(50, 2'b01, cyc);
      wait_done(50, 2'b10, cyc);

      // Fairness with both requests held; zero operand passes through unchanged
      multiplicand0 = 64'd1000; multiplier0 = 64'd3;
      multiplicand1 = 64'd0;    multiplier1 = 64'd77;
      push(2'b01, 128'd3000, 1'b0);
      push(2'b10, 128'd0, 1'b0);
      push(2'b01, 128'd3000, 1'b0);
      push(2'b10, 128'd0, 1'b0);
      req = 2'b11;
      wait_done(50, 2'b00, cyc);
      wait_done(50, 2'b00, cyc);
      wait_done(50, 2'b00, cyc);
      wait_done(50, 2'b11, cyc);

      // Single requester, 5-cycle multiplier
      lat = 5;
      multiplicand0 = 64'd6; multiplier0 = 64'd7;
      push(2'b01, 128'd42, 1'b0);
      req = 2'b01;
      wait_done(50, 2'b01, cyc);
      lat = 3;

      // Full width
      multiplicand1 = 64'hFFFF_FFFF_FFFF_FFFF;
      multiplier1   = 64'hFFFF_FFFF_FFFF_FFFF;
      push(2'b10, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 1'b0);
      req = 2'b10;
      wait_done(50, 2'b10, cyc);

      // Reset two cycles after start
      lat = 20;
      multiplicand0 = 64'd5; multiplier0 = 64'd5;
      req = 2'b01;
      wait_start(20);
      @(negedge clk);
      @(negedge clk);
      d0 = done_cnt;
      c0 = clear_cnt;
      reset = 1'b1;
      @(negedge clk);
      check("rstwait_grant", grant, 2'b00);
      check("rstwait_done", done, 2'b00);
      check("rstwait_opstart", mbus.m_opstart, 1'b0);
      reset = 1'b0;
      req   = 2'b00;
      pend_base++;
      lat = 3;
      repeat (20) @(negedge clk);
      check("rstwait_no_done", done_cnt, d0);
      check("rstwait_no_clear", clear_cnt, c0);
      multiplicand0 = 64'd11; multiplier0 = 64'd13;
      push(2'b01, 128'd143, 1'b0);
      req = 2'b01;
      wait_done(50, 2'b01, cyc);

      // Multiplier that never finishes
      hang = 1'b1;
      multiplicand1 = 64'd9; multiplier1 = 64'd9;
`ifdef MUL_ARB_TIMEOUT_EN
      push(2'b10, 128'd0, 1'b1);
      req = 2'b10;
      wait_start(20);
      wait_done(50, 2'b10, cyc);
      check("timeout_cycles", cyc, TOUT);
      hang = 1'b0;
`else
      req = 2'b10;
      wait_start(20);
      d0 = done_cnt;
      repeat (300) @(negedge clk);
      check("hang_no_done", done_cnt, d0);
      check("hang_grant_held", grant, 2'b10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      req   = 2'b00;
      hang  = 1'b0;
      pend_base++;
      @(negedge clk);
`endif
      multiplicand0 = 64'd100; multiplier0 = 64'd100;
      push(2'b01, 128'd10000, 1'b0);
      req = 2'b01;
      wait_done(50, 2'b01, cyc);

      repeat (3) @(negedge clk);
      check("total_dones", done_cnt, exp_ops);
`ifdef MUL_ARB_TIMEOUT_EN
      check("total_errors", err_cnt, 1);
`else
      check("total_errors", err_cnt, 0);
`endif
      check("grant_never_both", {127'b0, bad_grant}, 128'd0);
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one sequential 64x64 multiplier between two requesters (e.g. two factorial cores).
- Accepts requests with operands and grants them round-robin.
- Sequences the multiplier through start / wait-for-done / clear, then returns the 128-bit product to the granted requester with a one-cycle done pulse.
- Sits between the factorial controllers and the shared multiplier instance.

Parameters:
- WIDTH, 64, operand width; product is 2*WIDTH.
- TIMEOUT, 255, max cycles in WAIT before abort; used only with MUL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous reset, active-high
- req  in  2  request per requester, level; held until matching done
- multiplicand0, multiplier0  in  WIDTH each  requester 0 operands, stable while req[0]=1
- multiplicand1, multiplier1  in  WIDTH each  requester 1 operands, stable while req[1]=1
- grant  out  2  one-hot, the requester currently being served
- done  out  2  one-cycle pulse to the served requester when result is valid
- result  out  2*WIDTH  product, held until the next done
- error  out  1  one-cycle pulse on timeout abort (0 when the macro is off)
- m_opstart  out  1  one-cycle start pulse to the multiplier
- m_opclear  out  1  one-cycle clear pulse to the multiplier
- m_multiplicand, m_multiplier  out  WIDTH each  operands to the multiplier
- m_opdone  in  1  multiplier finished, level, held until clear
- m_result  in  2*WIDTH  multiplier product, valid while m_opdone=1

Behaviour:
- Reset (synchronous): state=IDLE, grant=0, done=0, result=0, error=0, m_opstart=0, m_opclear=0, m_operands=0, last-served pointer=1 so requester 0 wins first.
- Reset asserted mid-operation: returns to IDLE next edge. No done is issued. m_opclear is not pulsed; the multiplier shares the same reset.
- States: IDLE -> LOAD -> START -> WAIT -> DONE -> CLEAR -> IDLE.
- IDLE:
  - Neither req bit set: stay.
  - Exactly one set: grant it.
  - Both set: grant the one not served last (round-robin).
  - Go to LOAD; grant is registered and held through CLEAR.
- LOAD: latch the granted operands onto m_multiplicand/m_multiplier. Go to START.
- START: m_opstart=1 for exactly this cycle. Go to WAIT.
- WAIT: stay until m_opdone=1, then latch m_result into result and go to DONE.
- DONE: done[granted]=1 for exactly this cycle. Update the last-served pointer. Go to CLEAR.
- CLEAR: m_opclear=1 for exactly this cycle. grant is dropped at the end of this cycle. Go to IDLE.
- Minimum turnaround: a new grant is possible the cycle after CLEAR, so back-to-back requests cost 3 overhead cycles (IDLE, LOAD, START) plus the multiplier latency.
- A req that drops while granted is ignored: the operation completes and done is still pulsed. The requester must not drop req before done.
- A req rising during an operation waits in IDLE arbitration; no request is lost.
- m_opdone already high in START (stale) is ignored; only WAIT samples m_opdone.
- Operand zero or one is not special-cased; the multiplier handles it.
- result keeps its value after done until overwritten; width is exactly 2*WIDTH, no truncation.

Optional Feature:
- Macro: MUL_ARB_TIMEOUT_EN.
- With it: a counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT without m_opdone:
  - result=0, error=1 for one cycle together with done[granted]=1;
  - then CLEAR pulses m_opclear and the state returns to IDLE;
  - the last-served pointer is updated as normal.
- Without it: no counter; WAIT waits indefinitely; error tied to 0.

Test Plan:
- Single requester: req=2'b01, operands 6 and 7, multiplier model done after 5 cycles -> m_opstart one pulse, done=2'b01 one pulse, result=42, m_opclear pulse the cycle after done, grant=0 after CLEAR.
- Simultaneous requests from reset: req=2'b11, r0 12x12, r1 3x5 -> r0 served first (result 144), then r1 (result 15), one done pulse each, no overlap in grant.
- Fairness: both reqs held continuously for 4 operations -> grant order 0,1,0,1.
- Full width: 64'hFFFF_FFFF_FFFF_FFFF squared -> result 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Reset in WAIT: assert reset 2 cycles after m_opstart -> next cycle state IDLE, grant=0, done never pulses; a subsequent request completes correctly.
- Timeout (with macro, TIMEOUT=8): multiplier never asserts m_opdone -> after 8 WAIT cycles, done and error pulse together, result=0, m_opclear pulses, next request is served normally. Without the macro, the same stimulus stays in WAIT.
